// File: rtl/bitonic_sort_ctrl_if.sv
// Handshake bundle for bitonic_sort_ctrl: serial load side and serial unload side.
// Signals: in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy,
// plus sort_dir when BITONIC_DIR_EN is defined.
interface bitonic_sort_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
`ifdef BITONIC_DIR_EN
    logic              sort_dir;

    modport slave (
        input  in_valid, in_data, out_ready, sort_dir,
        output in_ready, out_valid, out_data, busy
    );
    modport master (
        output in_valid, in_data, out_ready, sort_dir,
        input  in_ready, out_valid, out_data, busy
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// Sequential 8-entry bitonic sorter: serial load, 6 compare-exchange steps
// (one per cycle), serial unload. Ports: clk, rst_n (async, active-low),
// bus (bitonic_sort_ctrl_if.slave). Macro BITONIC_DIR_EN adds a per-block
// direction taken from bus.sort_dir on the first load of each block.
module bitonic_sort_ctrl #(
    parameter int DATA_W = 8,
    parameter int ASCEND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitonic_sort_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        OUT
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_n;
    logic [2:0]        r_step;
    logic [2:0]        w_step_n;
    logic [DATA_W-1:0] r_bank   [8];
    logic [DATA_W-1:0] w_sorted [8];
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_dir;
    logic [3:0]        w_k;
    logic [2:0]        w_j;
    logic [2:0]        w_lo;
    logic [2:0]        w_hi;
    logic              w_asc;
    logic              w_swap;

    assign w_in_xfer  = bus.in_valid  && (r_state == LOAD);
    assign w_out_xfer = bus.out_ready && (r_state == OUT);

`ifdef BITONIC_DIR_EN
    logic r_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dir <= (ASCEND != 0);
        else if (w_in_xfer && (r_idx == 3'd0))
            r_dir <= bus.sort_dir;
    end

    assign w_dir = r_dir;
`else
    assign w_dir = (ASCEND != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= LOAD;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_step_n  = r_step;
        unique case (r_state)
            LOAD: begin
                if (w_in_xfer) begin
                    w_idx_n = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_n = SORT;
                        w_step_n  = 3'd0;
                    end
                end
            end
            SORT: begin
                w_step_n = r_step + 3'd1;
                if (r_step == 3'd5) begin
                    w_state_n = OUT;
                    w_idx_n   = 3'd0;
                    w_step_n  = 3'd0;
                end
            end
            OUT: begin
                if (w_out_xfer) begin
                    w_idx_n = r_idx + 3'd1;
                    if (r_idx == 3'd7)
                        w_state_n = LOAD;
                end
            end
            default: begin
                w_state_n = LOAD;
                w_idx_n   = 3'd0;
                w_step_n  = 3'd0;
            end
        endcase
    end

    // One bitonic step over the whole bank. Pairs are (i, i|j) for every i
    // with bit j clear, i.e. four disjoint compare-exchanges per step.
    always_comb begin
        w_sorted = r_bank;
        w_k      = 4'd2;
        w_j      = 3'd1;
        w_lo     = 3'd0;
        w_hi     = 3'd0;
        w_asc    = 1'b0;
        w_swap   = 1'b0;
        unique case (r_step)
            3'd0: begin w_k = 4'd2; w_j = 3'd1; end
            3'd1: begin w_k = 4'd4; w_j = 3'd2; end
            3'd2: begin w_k = 4'd4; w_j = 3'd1; end
            3'd3: begin w_k = 4'd8; w_j = 3'd4; end
            3'd4: begin w_k = 4'd8; w_j = 3'd2; end
            3'd5: begin w_k = 4'd8; w_j = 3'd1; end
            default: begin w_k = 4'd2; w_j = 3'd1; end
        endcase
        for (int i = 0; i < 8; i++) begin
            w_lo = 3'(i);
            if ((w_lo & w_j) == 3'd0) begin
                w_hi   = w_lo | w_j;
                w_asc  = ((({1'b0, w_lo}) & w_k) == 4'd0) ^ ~w_dir;
                w_swap = w_asc ? (r_bank[w_lo] > r_bank[w_hi])
                               : (r_bank[w_lo] < r_bank[w_hi]);
                if (w_swap) begin
                    w_sorted[w_lo] = r_bank[w_hi];
                    w_sorted[w_hi] = r_bank[w_lo];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 3'd0;
            r_step <= 3'd0;
            r_bank <= '{default: '0};
        end else begin
            r_idx  <= w_idx_n;
            r_step <= w_step_n;
            if (w_in_xfer)
                r_bank[r_idx] <= bus.in_data;
            else if (r_state == SORT)
                r_bank <= w_sorted;
        end
    end

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_data  = (r_state == OUT) ? r_bank[r_idx] : '0;
    assign bus.busy      = (r_state != LOAD);

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl: one ascending and one descending
// instance, selected by tb sel; load, sort latency, unload and abort checks.
module tb_bitonic_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       sort_dir = 1'b1;

    logic [7:0] vin  [8];
    logic [7:0] vexp [8];

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    bitonic_sort_ctrl_if #(.DATA_W(8)) if_a ();
    bitonic_sort_ctrl_if #(.DATA_W(8)) if_d ();

    assign if_a.in_valid  = in_valid  && !sel;
    assign if_a.in_data   = in_data;
    assign if_a.out_ready = out_ready && !sel;
    assign if_d.in_valid  = in_valid  && sel;
    assign if_d.in_data   = in_data;
    assign if_d.out_ready = out_ready && sel;
`ifdef BITONIC_DIR_EN
    assign if_a.sort_dir  = sort_dir;
    assign if_d.sort_dir  = sort_dir;
`endif

    wire       o_ir = sel ? if_d.in_ready  : if_a.in_ready;
    wire       o_ov = sel ? if_d.out_valid : if_a.out_valid;
    wire [7:0] o_od = sel ? if_d.out_data  : if_a.out_data;
    wire       o_bz = sel ? if_d.busy      : if_a.busy;

    bitonic_sort_ctrl #(.DATA_W(8), .ASCEND(1)) u_asc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    bitonic_sort_ctrl #(.DATA_W(8), .ASCEND(0)) u_dsc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Load vin[0..7]; with gaps, in_valid is low every other cycle.
    // in_valid is left high afterwards to prove no extra loads occur.
    task automatic load8(input bit gaps, input bit dir_first,
                         input bit dir_toggle);
        int  i = 0;
        int  t = 0;
        bit  x;
        while (i < 8 && t < 100) begin
            in_valid = gaps ? ((t % 2) == 0) : 1'b1;
            in_data  = vin[i];
            sort_dir = (i == 0 || !dir_toggle) ? dir_first : ~dir_first;
            x = in_valid && o_ir;
            @(posedge clk);
            if (x) i++;
            t++;
            @(negedge clk);
        end
        chk("load_count", i, 8);
        sort_dir = dir_first;
    endtask

    task automatic wait_ov(input int budget);
        cyc = 0;
        while (!o_ov && cyc < budget) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("out_valid_wait", o_ov, 1);
    endtask

    task automatic unload8(input int stall);
        for (int n = 0; n < 8; n++) begin
            wait_ov(40);
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_data", o_od, vexp[n]);
                chk("hold_busy", o_bz, 1);
            end
            chk($sformatf("out%0d", n), o_od, vexp[n]);
            out_ready = 1'b1;
            if (n == 7) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("in_ready_back", o_ir, 1);
        chk("busy_back", o_bz, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_in_ready", o_ir, 1);
        chk("rst_out_valid", o_ov, 0);
        chk("rst_out_data", o_od, 0);
        chk("rst_busy", o_bz, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ascending, continuous valid/ready, latency check.
        sel  = 1'b0;
        vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load8(1'b0, 1'b1, 1'b0);
        chk("sort_in_ready", o_ir, 0);
        chk("sort_busy", o_bz, 1);
        wait_ov(20);
        chk("latency", cyc, 6);
        unload8(0);

        // Descending instance with duplicates.
        sel  = 1'b1;
        vin  = '{8'd3, 8'd200, 8'd3, 8'd0, 8'd255, 8'd17, 8'd200, 8'd1};
        vexp = '{8'd255, 8'd200, 8'd200, 8'd17, 8'd3, 8'd3, 8'd1, 8'd0};
        load8(1'b0, 1'b0, 1'b0);
        unload8(0);

        // Same block again under output backpressure.
        load8(1'b0, 1'b0, 1'b0);
        unload8(5);

        // Gapped input, valid held through SORT and OUT.
        sel  = 1'b0;
        vin  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        vexp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        load8(1'b1, 1'b1, 1'b0);
        unload8(0);

        // Abort during step 3, then a fresh block.
        vin = '{8'd9, 8'd250, 8'd0, 8'd77, 8'd3, 8'd128, 8'd64, 8'd2};
        load8(1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", o_ov, 0);
        chk("abort_in_ready", o_ir, 1);
        chk("abort_busy", o_bz, 0);
        chk("abort_out_data", o_od, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vin  = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1};
        vexp = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd5, 8'd5, 8'd5};
        load8(1'b0, 1'b1, 1'b0);
        unload8(0);

`ifdef BITONIC_DIR_EN
        vin  = '{8'd4, 8'd1, 8'd3, 8'd2, 8'd8, 8'd6, 8'd7, 8'd5};
        vexp = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load8(1'b0, 1'b0, 1'b1);
        unload8(0);
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load8(1'b0, 1'b1, 1'b1);
        unload8(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
